mmio_uart_responder: RTL
========================

Name: mmio_uart_responder

Overview:
- Peripheral-side responder for the UART slice of the MMIO bus: the memory controller drives tx_wen, rx_ren, uart_addr and uart_din, and samples uart_dout. Its UART window is 0xAAAAA400–0xAAAAA407.
- Contains a TX FIFO feeding an 8N1 serializer and an RX FIFO fed by a byte-level receiver.
- Exposes a data register and a status register to the CPU.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200).
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- tx_wen  in  1  bus write strobe for the UART window; one access per asserted cycle
- rx_ren  in  1  bus read strobe for the UART window; one access per asserted cycle
- uart_addr  in  3  byte offset within the window
- uart_din  in  8  write data
- uart_dout  out  8  read data; combinational, valid in the same cycle as the strobe
- tx  out  1  serial output
- rx_byte  in  8  received byte from the deserializer
- rx_valid  in  1  one-cycle pulse; rx_byte is valid
- tx_full  out  1  TX FIFO full
- rx_data_present  out  1  RX FIFO non-empty
- rx_overrun  out  1  sticky: a byte was dropped because the RX FIFO was full

Behaviour:
- Reset (rst==0 at a clk edge):
  - both FIFOs are emptied;
  - the TX FSM goes to IDLE;
  - tx=1, rx_overrun=0, tx_full=0, rx_data_present=0;
  - a frame in flight is abandoned and tx returns high after that edge.
- Register map, decoded on uart_addr[2]:
  - 0 = DATA.
  - 1 = STATUS = {4'b0, rx_overrun, tx_busy, tx_full, rx_data_present}.
  - uart_addr[1:0] is ignored.
- uart_dout is combinational:
  - DATA: the RX FIFO head, or 8'h00 when the RX FIFO is empty.
  - STATUS: the current status.
  - It is driven regardless of the strobes, because the controller registers it at the edge that ends the access.
- DATA write (tx_wen, addr[2]==0):
  - pushes uart_din at the edge if TX is not full;
  - if TX is full, the byte is dropped silently with no state change.
- STATUS write: ignored.
- DATA read (rx_ren, addr[2]==0):
  - pops the RX head at the edge if RX is non-empty;
  - if RX is empty, no effect and uart_dout=0.
- STATUS read: clears rx_overrun at the edge, unless an overrun occurs in the same cycle, in which case rx_overrun stays 1.
- tx_wen and rx_ren both high in one cycle: the write is honoured and the read has no side effect.
- RX push:
  - rx_valid pushes rx_byte if RX is not full.
  - If RX is full and no pop occurs that cycle, the byte is dropped and rx_overrun is set.
  - If RX is full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged.
- FIFOs:
  - circular buffers with read/write pointers of log2(FIFO_DEPTH) bits that wrap, plus a count of log2(FIFO_DEPTH)+1 bits;
  - full when count==FIFO_DEPTH; empty when count==0.
  - tx_full and rx_data_present are derived combinationally from the counts.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
  - IDLE: tx=1. If the TX FIFO is non-empty at an edge, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], sent LSB first, CLKS_PER_BIT cycles per bit, 8 bits; then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- TX timing:
  - A write at edge N into an empty FIFO with the FSM idle: START is entered at edge N+1, so tx falls after N+1.
  - A frame lasts 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 idle-high cycle between them.
  - tx is a registered output.
- tx_busy = (state != IDLE).
- A TX push and a TX pop in the same cycle leave the count unchanged. A push to a full TX FIFO is dropped even if a pop occurs in that cycle.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset, then write DATA 0xA5 → tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. tx_busy is 1 for 40 cycles. STATUS reads 0x00 afterwards.
2. Five DATA writes 0x01–0x05 on consecutive cycles → the first is popped to the shifter. tx_full becomes 1 after the 5th write, which is accepted. A 6th write of 0x06 is dropped. The serial output shows 0x01–0x05 in order, with 1-cycle gaps between frames.
3. Pulse rx_valid with 0x11, 0x22 → STATUS=0x01. DATA reads return 0x11 and then 0x22. A third read returns 0x00 and STATUS=0x00.
4. Push 5 RX bytes with no reads → STATUS=0x09 (overrun + present). A STATUS read clears it; the next STATUS read gives 0x01. Draining returns the first 4 bytes only.
5. RX full, with rx_valid 0x77 and a DATA read in the same cycle → the read returns the oldest byte, the count stays 4, 0x77 is the last byte drained, and rx_overrun stays 0.
6. Mid-frame (during DATA bit 3), assert rst=0 for 1 cycle → tx=1 on the next cycle. Both FIFOs are empty, STATUS=0x00, and no further frame is sent.

Source files
------------

// File: rtl/mmio_uart_responder.sv
// -----------------------------------------------------------------------------
// mmio_uart_responder
//
// Peripheral-side responder for the UART slice of the MMIO bus. The memory
// controller strobes tx_wen / rx_ren with a byte offset in uart_addr and
// samples uart_dout combinationally in the same cycle. Internally there is a
// TX FIFO feeding an 8N1 serializer and an RX FIFO filled from an external
// byte-level deserializer.
//
// Register map (decoded on uart_addr[2], uart_addr[1:0] ignored):
//   0 : DATA   write pushes TX FIFO, read pops RX FIFO (0x00 when empty)
//   1 : STATUS {4'b0, rx_overrun, tx_busy, tx_full, rx_data_present}
//               reading it clears rx_overrun; writes are ignored
//
// Ports:
//   clk             system clock
//   rst             synchronous reset, active-low
//   tx_wen          bus write strobe, one access per asserted cycle
//   rx_ren          bus read strobe, one access per asserted cycle
//   uart_addr[2:0]  byte offset within the UART window
//   uart_din[7:0]   write data
//   uart_dout[7:0]  read data, combinational
//   tx              serial output (registered, idles high)
//   rx_byte[7:0]    received byte from the deserializer
//   rx_valid        one-cycle pulse qualifying rx_byte
//   tx_full         TX FIFO full
//   rx_data_present RX FIFO non-empty
//   rx_overrun      sticky, a received byte was dropped on a full RX FIFO
//
// FIFO_DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// CLKS_PER_BIT must be at least 2.
// -----------------------------------------------------------------------------
module mmio_uart_responder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wen,
    input  logic       rx_ren,
    input  logic [2:0] uart_addr,
    input  logic [7:0] uart_din,
    output logic [7:0] uart_dout,
    output logic       tx,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       tx_full,
    output logic       rx_data_present,
    output logic       rx_overrun
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]  CNT_ZERO = '0;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } txState_t;

    // TX FIFO storage and bookkeeping
    logic [7:0]    r_txMem [FIFO_DEPTH];
    logic [AW-1:0] r_txWrPtr;
    logic [AW-1:0] r_txRdPtr;
    logic [CW-1:0] r_txCount;

    // RX FIFO storage and bookkeeping
    logic [7:0]    r_rxMem [FIFO_DEPTH];
    logic [AW-1:0] r_rxWrPtr;
    logic [AW-1:0] r_rxRdPtr;
    logic [CW-1:0] r_rxCount;

    // Serializer state
    txState_t      r_state;
    logic [BCW-1:0] r_bitCnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_rxOverrun;

    // Decoded strobes and derived flags
    logic       w_isData;
    logic       w_readAccess;
    logic       w_txFull;
    logic       w_txEmpty;
    logic       w_rxFull;
    logic       w_rxEmpty;
    logic       w_txPush;
    logic       w_txPop;
    logic       w_rxPush;
    logic       w_rxPop;
    logic       w_overrunEvent;
    logic       w_statusRead;
    logic       w_txBusy;
    logic [7:0] w_status;
    logic       w_unusedAddrBits;

    // Only uart_addr[2] selects a register; the low offset bits alias.
    assign w_unusedAddrBits = ^uart_addr[1:0];

    assign w_isData  = ~uart_addr[2];
    assign w_txFull  = (r_txCount == CNT_FULL);
    assign w_txEmpty = (r_txCount == CNT_ZERO);
    assign w_rxFull  = (r_rxCount == CNT_FULL);
    assign w_rxEmpty = (r_rxCount == CNT_ZERO);
    assign w_txBusy  = (r_state != S_IDLE);

    // A simultaneous write wins the bus cycle, so the read side effects
    // (RX pop, overrun clear) are suppressed whenever tx_wen is high.
    assign w_readAccess = rx_ren & ~tx_wen;

    // A write to a full TX FIFO is dropped even if the serializer pops in
    // the same cycle; fullness is judged on the count before the edge.
    assign w_txPush = tx_wen & w_isData & ~w_txFull;

    // The serializer takes the next byte whenever it sits idle.
    assign w_txPop = (r_state == S_IDLE) & ~w_txEmpty;

    assign w_rxPop      = w_readAccess & w_isData & ~w_rxEmpty;
    assign w_statusRead = w_readAccess & uart_addr[2];

    // A pop in the same cycle frees a slot, so a full RX FIFO can still
    // accept the incoming byte; otherwise the byte is lost and flagged.
    assign w_rxPush       = rx_valid & (~w_rxFull | w_rxPop);
    assign w_overrunEvent = rx_valid & w_rxFull & ~w_rxPop;

    assign w_status = {4'b0000, r_rxOverrun, w_txBusy, w_txFull, ~w_rxEmpty};

    assign tx              = r_tx;
    assign tx_full         = w_txFull;
    assign rx_data_present = ~w_rxEmpty;
    assign rx_overrun      = r_rxOverrun;

    // Read data is combinational so the controller can register it at the
    // edge that ends the access. It is driven whether or not a strobe is up.
    always_comb begin
        uart_dout = 8'h00;
        if (uart_addr[2]) begin
            uart_dout = w_status;
        end else if (!w_rxEmpty) begin
            uart_dout = r_rxMem[r_rxRdPtr];
        end
    end

    // TX FIFO storage. Kept free of reset so it can map onto plain RAM;
    // stale contents are unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_txPush) begin
            r_txMem[r_txWrPtr] <= uart_din;
        end
    end

    // TX FIFO pointers and occupancy. Push and pop in one cycle cancel out
    // in the count while both pointers advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) begin
                r_txWrPtr <= r_txWrPtr + PTR_ONE;
            end
            if (w_txPop) begin
                r_txRdPtr <= r_txRdPtr + PTR_ONE;
            end
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + CNT_ONE;
                2'b01:   r_txCount <= r_txCount - CNT_ONE;
                default: r_txCount <= r_txCount;
            endcase
        end
    end

    // RX FIFO storage, written from the deserializer side.
    always_ff @(posedge clk) begin
        if (w_rxPush) begin
            r_rxMem[r_rxWrPtr] <= rx_byte;
        end
    end

    // RX FIFO pointers and occupancy, mirroring the TX side.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) begin
                r_rxWrPtr <= r_rxWrPtr + PTR_ONE;
            end
            if (w_rxPop) begin
                r_rxRdPtr <= r_rxRdPtr + PTR_ONE;
            end
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + CNT_ONE;
                2'b01:   r_rxCount <= r_rxCount - CNT_ONE;
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    // Sticky overrun flag. A new overrun in the same cycle as a STATUS read
    // takes priority so the event is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rxOverrun <= 1'b0;
        end else if (w_overrunEvent) begin
            r_rxOverrun <= 1'b1;
        end else if (w_statusRead) begin
            r_rxOverrun <= 1'b0;
        end
    end

    // 8N1 serializer. tx is registered and always updated together with the
    // state so the line level for each phase appears right after the edge
    // that enters it. Popping in IDLE and going straight to START gives the
    // single idle-high cycle between back-to-back frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_bitCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx     <= 1'b1;
                    r_bitCnt <= '0;
                    r_bitIdx <= '0;
                    if (!w_txEmpty) begin
                        r_shift <= r_txMem[r_txRdPtr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_bitCnt == BIT_LAST) begin
                        r_bitCnt <= '0;
                        r_bitIdx <= '0;
                        r_state  <= S_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_bitCnt <= r_bitCnt + BIT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_bitCnt == BIT_LAST) begin
                        r_bitCnt <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt + BIT_ONE;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_bitCnt == BIT_LAST) begin
                        r_bitCnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_bitCnt <= r_bitCnt + BIT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
